// File: rtl/pc_branch_sequencer.sv
// Multicycle PC sequencer: owns PC and carry flag, sequences fetch/exec/update
// and resolves every branch opcode against sign, zero and carry.
module pc_branch_sequencer #(
   parameter int unsigned     PC_W     = 32,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter logic [5:0]      HALT_OP  = 6'b111111
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   input  logic            imem_ack,
   input  logic [5:0]      opcode,
   input  logic            rs_sign,
   input  logic            rs_zero,
   input  logic            alu_carry,
   input  logic            carry_we,
   input  logic [PC_W-1:0] br_target,
   input  logic [PC_W-1:0] reg_target,
   output logic [PC_W-1:0] pc,
   output logic            link_we,
   output logic [PC_W-1:0] link_data,
   output logic            branch_taken,
   output logic            flush,
   output logic            busy
);

   localparam int unsigned OP_W = 6;

   localparam logic [OP_W-1:0] OP_BLTZ = 6'b000111;
   localparam logic [OP_W-1:0] OP_BZ   = 6'b001000;
   localparam logic [OP_W-1:0] OP_BNZ  = 6'b001001;
   localparam logic [OP_W-1:0] OP_BR   = 6'b001010;
   localparam logic [OP_W-1:0] OP_B    = 6'b001011;
   localparam logic [OP_W-1:0] OP_BL   = 6'b001100;
   localparam logic [OP_W-1:0] OP_BCY  = 6'b001101;
   localparam logic [OP_W-1:0] OP_BNCY = 6'b001110;

   typedef enum logic [2:0] {
      S_INIT,
      S_FETCH,
      S_EXEC,
      S_UPDATE,
      S_HALT
   } state_t;

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q;
   logic [OP_W-1:0] op_q;
   logic            carry_q;
   logic            taken_q;
   logic            imem_req_q;
   logic            busy_q;
   logic            branch_taken_q;
   logic            flush_q;
   logic            link_we_q;
   logic [PC_W-1:0] link_data_q;

   logic            cond_c;
   logic [PC_W-1:0] pc_inc_c;
   logic [PC_W-1:0] target_sel_c;
   logic [PC_W-1:0] target_c;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_INIT;
      else        state_q <= state_d;
   end

   // Next state, branch condition and redirect target
   always_comb begin
      state_d      = state_q;
      cond_c       = 1'b0;
      pc_inc_c     = pc_q + PC_W'(4);
      target_sel_c = (op_q == OP_BR) ? reg_target : br_target;
      target_c     = {target_sel_c[PC_W-1:2], 2'b00};

      case (op_q)
         OP_BLTZ:           cond_c = rs_sign;
         OP_BZ:             cond_c = rs_zero;
         OP_BNZ:            cond_c = !rs_zero;
         OP_BR, OP_B, OP_BL: cond_c = 1'b1;
         OP_BCY:            cond_c = carry_q;
         OP_BNCY:           cond_c = !carry_q;
         default:           cond_c = 1'b0;
      endcase

      case (state_q)
         S_INIT:   state_d = S_FETCH;
         S_FETCH:  if (imem_ack) state_d = S_EXEC;
         S_EXEC:   state_d = S_UPDATE;
         S_UPDATE: state_d = (op_q == HALT_OP) ? S_HALT : S_FETCH;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_INIT;
      endcase
   end

   // Datapath registers; outputs are registered from the next state so they
   // line up with the state they belong to
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q           <= RESET_PC;
         op_q           <= '0;
         carry_q        <= 1'b0;
         taken_q        <= 1'b0;
         imem_req_q     <= 1'b0;
         busy_q         <= 1'b1;
         branch_taken_q <= 1'b0;
         flush_q        <= 1'b0;
         link_we_q      <= 1'b0;
         link_data_q    <= '0;
      end else begin
         if (state_q == S_FETCH && imem_ack) op_q <= opcode;
         if (state_q == S_EXEC)              taken_q <= cond_c;
         if (state_q == S_UPDATE)            pc_q <= taken_q ? target_c : pc_inc_c;
         if (state_q != S_HALT && carry_we)  carry_q <= alu_carry;

         imem_req_q     <= (state_d == S_FETCH);
         busy_q         <= (state_d != S_HALT);
         branch_taken_q <= (state_q == S_EXEC) && cond_c;
         flush_q        <= (state_q == S_EXEC) && cond_c;
         link_we_q      <= (state_q == S_EXEC) && (op_q == OP_BL);
         if (state_q == S_EXEC && op_q == OP_BL) link_data_q <= pc_inc_c;
      end
   end

   assign pc           = pc_q;
   assign imem_req     = imem_req_q;
   assign busy         = busy_q;
   assign branch_taken = branch_taken_q;
   assign flush        = flush_q;
   assign link_we      = link_we_q;
   assign link_data    = link_data_q;

endmodule

// File: tb/tb_pc_branch_sequencer.sv
// Randomized scoreboard bench for pc_branch_sequencer: the driver predicts each
// instruction's outcome, a negedge monitor checks pulses and PC as they appear.
module tb_pc_branch_sequencer;

   localparam int unsigned PC_W = 32;
   localparam logic [5:0]  HALT = 6'b111111;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            imem_req, imem_ack;
   logic [5:0]      opcode;
   logic            rs_sign, rs_zero, alu_carry, carry_we;
   logic [PC_W-1:0] br_target, reg_target, pc, link_data;
   logic            link_we, branch_taken, flush, busy;

   always #5 clk = ~clk;

   pc_branch_sequencer #(.PC_W(PC_W), .RESET_PC('0), .HALT_OP(HALT)) dut (
      .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_ack(imem_ack),
      .opcode(opcode), .rs_sign(rs_sign), .rs_zero(rs_zero),
      .alu_carry(alu_carry), .carry_we(carry_we), .br_target(br_target),
      .reg_target(reg_target), .pc(pc), .link_we(link_we),
      .link_data(link_data), .branch_taken(branch_taken), .flush(flush),
      .busy(busy)
   );

   typedef struct packed {
      logic            taken;
      logic            lw;
      logic [PC_W-1:0] ld;
      logic [PC_W-1:0] npc;
   } exp_t;

   exp_t        exp_q[$];
   int          total = 0;
   int          bad   = 0;
   logic [31:0] m_pc;
   logic        m_carry;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Architectural outcome of one instruction, from the opcode table
   function automatic exp_t predict(input logic [5:0] op, input logic sign, input logic zero,
                                    input logic carry, input logic [31:0] cur_pc,
                                    input logic [31:0] bt, input logic [31:0] rt);
      exp_t e;
      logic t;
      case (op)
         6'd7:               t = sign;
         6'd8:               t = zero;
         6'd9:               t = !zero;
         6'd10, 6'd11, 6'd12: t = 1'b1;
         6'd13:              t = carry;
         6'd14:              t = !carry;
         default:            t = 1'b0;
      endcase
      e.taken = t;
      e.lw    = (op == 6'd12);
      e.ld    = cur_pc + 32'd4;
      e.npc   = t ? (((op == 6'd10) ? rt : bt) & 32'hFFFF_FFFC) : cur_pc + 32'd4;
      return e;
   endfunction

   // One instruction: optional FETCH waits, ack, EXEC, UPDATE
   task automatic run_instr(input logic [5:0] op, input logic sign, input logic zero,
                            input logic [31:0] bt, input logic [31:0] rt, input int waits,
                            input logic cw_f, input logic cw_e, input logic ac);
      int   n = 0;
      logic cw, a;
      exp_t e;
      while (imem_req !== 1'b1 && n < 8) begin
         cyc();
         n++;
      end
      chk("imem_req_in_fetch", 32'(imem_req), 32'd1);
      br_target  = bt;
      reg_target = rt;
      for (int i = 0; i < waits; i++) begin
         cw = 1'($urandom); a = 1'($urandom);
         imem_ack = 1'b0; opcode = 6'($urandom); carry_we = cw; alu_carry = a;
         cyc();
         if (cw) m_carry = a;
      end
      imem_ack = 1'b1; opcode = op; carry_we = cw_f; alu_carry = ac;
      cyc();
      if (cw_f) m_carry = ac;
      imem_ack = 1'($urandom); opcode = 6'($urandom);
      rs_sign = sign; rs_zero = zero; carry_we = cw_e; alu_carry = ac;
      e = predict(op, sign, zero, m_carry, m_pc, bt, rt);
      exp_q.push_back(e);
      m_pc = e.npc;
      cyc();
      if (cw_e) m_carry = ac;
      imem_ack = 1'($urandom); opcode = 6'($urandom);
      rs_sign = 1'($urandom); rs_zero = 1'($urandom);
      cyc();
      if (cw_e) m_carry = ac;
      imem_ack = 1'b0; carry_we = 1'b0;
   endtask

   // Monitor: handshake starts an instruction; pulses checked every cycle
   int   since = 99;
   exp_t mon_cur;
   always @(negedge clk) begin
      if (!rst_n) begin
         since = 99;
      end else begin
         if (since < 99) since++;
         if (since == 2) begin
            if (exp_q.size() == 0) begin
               chk("scoreboard_underflow", 32'd0, 32'd1);
               mon_cur = '0;
            end else begin
               mon_cur = exp_q.pop_front();
            end
         end
         chk("branch_taken", 32'(branch_taken), (since == 2) ? 32'(mon_cur.taken) : 32'd0);
         chk("flush", 32'(flush), (since == 2) ? 32'(mon_cur.taken) : 32'd0);
         chk("link_we", 32'(link_we), (since == 2) ? 32'(mon_cur.lw) : 32'd0);
         if (since == 2 && mon_cur.lw) chk("link_data", link_data, mon_cur.ld);
         if (since == 3) chk("pc_after_update", pc, mon_cur.npc);
         if (imem_req && imem_ack) since = 0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] op;
      rst_n = 1'b0; imem_ack = 1'b0; opcode = '0; rs_sign = 1'b0; rs_zero = 1'b0;
      alu_carry = 1'b0; carry_we = 1'b0; br_target = '0; reg_target = '0;
      m_pc = '0; m_carry = 1'b0;
      repeat (2) cyc();
      chk("reset_pc", pc, 32'd0);
      chk("reset_imem_req", 32'(imem_req), 32'd0);
      chk("reset_busy", 32'(busy), 32'd1);
      chk("reset_link_data", link_data, 32'd0);
      chk("reset_pulses", {29'd0, link_we, branch_taken, flush}, 32'd0);
      rst_n = 1'b1;
      #2 chk("init_no_req", 32'(imem_req), 32'd0);
      cyc();
      chk("first_req_cycle2", 32'(imem_req), 32'd1);

      repeat (3) run_instr(6'd0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0);
      run_instr(6'd13, 0, 0, 32'h100, 0, 0, 1, 0, 1);       // bcy, carry set
      run_instr(6'd14, 0, 0, 32'h200, 0, 0, 0, 0, 0);       // bncy -> 0x104
      run_instr(6'd11, 0, 0, 32'h10, 0, 0, 0, 0, 0);
      run_instr(6'd7, 1, 0, 32'h40, 0, 0, 0, 0, 0);         // bltz taken
      run_instr(6'd8, 0, 0, 32'h40, 0, 0, 0, 0, 0);         // bz not taken
      run_instr(6'd9, 0, 0, 32'h40, 0, 0, 0, 0, 0);         // bnz taken
      run_instr(6'd11, 0, 0, 32'h20, 0, 0, 0, 0, 0);
      run_instr(6'd12, 0, 0, 32'h80, 0, 0, 0, 0, 0);        // bl
      run_instr(6'd10, 0, 0, 32'h0, 32'h3B, 0, 0, 0, 0);    // br
      run_instr(6'd0, 0, 0, 0, 0, 0, 1, 0, 0);              // clear carry
      run_instr(6'd13, 0, 0, 32'h300, 0, 0, 0, 1, 1);       // same-cycle carry
      run_instr(6'd11, 0, 0, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
      run_instr(6'd0, 0, 0, 0, 0, 0, 0, 0, 0);              // wrap to 0
      chk("model_wrap", m_pc, 32'd0);

      for (int k = 0; k < 40; k++) begin
         case ($urandom % 10)
            0, 1, 2, 3, 4, 5, 6, 7: op = 6'(7 + ($urandom % 8));
            8:       op = 6'd0;
            default: begin
               op = 6'($urandom);
               if (op == HALT) op = 6'h3E;
            end
         endcase
         run_instr(op, 1'($urandom), 1'($urandom), $urandom, $urandom,
                   int'($urandom % 3), 1'($urandom), 1'($urandom), 1'($urandom));
      end

      run_instr(HALT, 0, 0, 32'h500, 32'h500, 1, 0, 0, 0);
      cyc();
      for (int k = 0; k < 10; k++) begin
         carry_we = 1'b1; alu_carry = 1'($urandom); imem_ack = 1'($urandom);
         chk("halt_busy", 32'(busy), 32'd0);
         chk("halt_imem_req", 32'(imem_req), 32'd0);
         chk("halt_pc", pc, m_pc);
         cyc();
      end
      carry_we = 1'b0; imem_ack = 1'b0;

      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      m_pc = '0; m_carry = 1'b0;
      exp_q.delete();
      cyc();
      run_instr(6'd11, 0, 0, 32'h500, 0, 0, 0, 0, 0);
      cyc();
      chk("midfetch_req_before", 32'(imem_req), 32'd1);
      chk("midfetch_pc_before", pc, 32'h500);
      opcode = 6'd12;
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_req", 32'(imem_req), 32'd0);
      chk("async_reset_pc", pc, 32'd0);
      cyc();
      rst_n = 1'b1;
      m_pc = '0; m_carry = 1'b0;
      exp_q.delete();
      repeat (2) run_instr(6'd0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) cyc();
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pc_branch_sequencer.md
Name: pc_branch_sequencer

Overview:
- Multicycle PC sequencer for the KGP-miniRISC core: owns the PC and carry flag register, sequences instruction fetch, and drives the branch decision for every instruction.
- Resolves all branch opcodes against sign, zero and carry.
- Redirects the PC, issues link writes for bl, and signals a flush on taken branches.
- Sits between instruction memory, the register file and ALU flags, and the fetch path.

Parameters:
- PC_W, 32: PC and target width.
- RESET_PC, 0: PC value loaded on reset.
- HALT_OP, 6'b111111: opcode that stops sequencing.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- imem_req  out  1  fetch request to instruction memory.
- imem_ack  in  1  fetch complete; opcode valid this cycle.
- opcode  in  6  opcode of the fetched instruction.
- rs_sign  in  1  MSB of the rs operand, valid in EXEC.
- rs_zero  in  1  rs operand == 0, valid in EXEC.
- alu_carry  in  1  ALU carry-out.
- carry_we  in  1  load alu_carry into the carry flag.
- br_target  in  PC_W  PC-relative or absolute branch target.
- reg_target  in  PC_W  register-indirect target for br.
- pc  out  PC_W  current PC.
- link_we  out  1  register-file write strobe for the link register (bl).
- link_data  out  PC_W  return address (old pc + 4).
- branch_taken  out  1  one-cycle pulse, branch redirected.
- flush  out  1  one-cycle pulse, discard younger fetch/decode state.
- busy  out  1  high in every state except HALT.

Behaviour:
- Reset (rst_n low, takes effect immediately, asynchronous):
  - state=INIT, pc=RESET_PC, carry_q=0, op_q=0.
  - imem_req, link_we, branch_taken and flush all 0; link_data=0.
- States: INIT -> FETCH -> EXEC -> UPDATE -> FETCH, plus HALT. All outputs are Moore-decoded from state and registers.
- INIT: one cycle, busy=1, no request; then FETCH.
- FETCH:
  - imem_req=1.
  - On imem_ack: op_q <= opcode, go to EXEC.
  - Without ack: hold FETCH with imem_req high, no timeout.
- EXEC: one cycle. taken_q <= cond(op_q) using rs_sign, rs_zero and the carry_q value held before this edge. Then UPDATE.
- Opcode decode (cond):
  - 000111 bltz: rs_sign.
  - 001000 bz: rs_zero.
  - 001001 bnz: !rs_zero.
  - 001010 br: 1, target=reg_target.
  - 001011 b: 1.
  - 001100 bl: 1, plus link write.
  - 001101 bcy: carry_q.
  - 001110 bncy: !carry_q.
  - Every other opcode: not taken, including HALT_OP.
- UPDATE: one cycle.
  - If taken_q: pc <= target with bits [1:0] forced to 0; branch_taken=1 and flush=1 this cycle.
  - Else: pc <= pc + 4.
  - For bl: link_we=1 and link_data = pc + 4, using pc before the update. link_we is asserted whether or not anything else stalls.
  - Next state: HALT if op_q==HALT_OP, else FETCH.
- HALT:
  - pc frozen; imem_req=0, busy=0, all pulses 0.
  - carry_we ignored. Only reset exits HALT.
- Carry flag:
  - carry_we is sampled every cycle except in HALT.
  - carry_q <= alu_carry on the next edge.
  - Same-cycle carry_we in EXEC does not affect that instruction's condition.
- Arithmetic: pc + 4 wraps modulo 2^PC_W. pc = 2^PC_W - 4 not-taken -> 0.
- imem_ack outside FETCH is ignored. opcode is sampled only on the FETCH+ack edge.
- Latency: 3 cycles per instruction with zero-wait ack (FETCH, EXEC, UPDATE). Each wait cycle in FETCH adds 1.
- Reset asserted in any state, including mid-FETCH with imem_req high: immediate return to INIT values, in-flight opcode discarded.
- Pulses (branch_taken, flush, link_we) never last more than one cycle per instruction.

Test Plan:
- Reset then zero-wait acks with opcode 000000 for 3 instructions -> pc goes 0, 4, 8, 12; imem_req first high in cycle 2 after reset release; branch_taken never asserted.
- bcy/bncy:
  - carry_we=1, alu_carry=1, then bcy with br_target=0x100 -> pc=0x100, branch_taken and flush high for exactly one cycle.
  - bncy with carry_q=1 and target 0x200 -> pc=0x104.
- bltz with rs_sign=1 taken; bz with rs_zero=0 not taken; bnz with rs_zero=0 taken.
  - All use br_target=0x40 from pc=0x10.
  - Required pc sequence: 0x40, then 0x44, then 0x40.
- bl from pc=0x20 with br_target=0x80 -> link_we=1 for one cycle, link_data=0x24, pc=0x80.
- br with reg_target=0x3B -> pc=0x38 (low bits cleared).
- carry_we=1 with alu_carry=1 in the same EXEC cycle as bcy, carry_q previously 0 -> bcy not taken, pc+4.
- pc=0xFFFFFFFC with a non-branch opcode -> pc wraps to 0x0.
- HALT_OP -> busy=0, imem_req=0, pc frozen for 10 cycles.
- rst_n pulsed low mid-FETCH with imem_req high -> imem_req=0 and pc=RESET_PC immediately, before the next clock edge.
